sgd_x_host_wr: RTL and testbench

SGD_X_HOST_WR -- requirements
Module: sgd_x_host_wr

---
 rtl/sgd_x_host_wr.sv | 210 +++++++++++++++++++++
 tb/tb_sgd_x_host_wr.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgd_x_host_wr.sv
// Model write-back engine: streams the model BRAM out to host memory as
// 512-bit lines, two 256-bit BRAM words per line, one line outstanding.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   started                          job running; low clears the epoch count
//   dimension                        feature count (8 features per BRAM word)
//   x_host_base_addr                 host byte address of the model region
//   writing_x_to_host_memory_en      level request to write the model back
//   writing_x_to_host_memory_done    one-cycle completion pulse
//   x_rd_en, x_rd_addr, x_rd_data    model BRAM read port (fixed latency)
//   mem_wr_valid/ready/addr/data     host write request channel
//   x_wb_epoch_count                 completed write-backs since started rose
module sgd_x_host_wr #(
    parameter int unsigned X_DATA_WIDTH = 256,
    parameter int unsigned X_ADDR_WIDTH = 12,
    parameter int unsigned RD_LATENCY   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    started,
    input  logic [31:0]             dimension,
    input  logic [63:0]             x_host_base_addr,
    input  logic                    writing_x_to_host_memory_en,
    output logic                    writing_x_to_host_memory_done,
    output logic                    x_rd_en,
    output logic [X_ADDR_WIDTH-1:0] x_rd_addr,
    input  logic [X_DATA_WIDTH-1:0] x_rd_data,
    output logic                    mem_wr_valid,
    input  logic                    mem_wr_ready,
    output logic [63:0]             mem_wr_addr,
    output logic [511:0]            mem_wr_data,
    output logic [15:0]             x_wb_epoch_count
);

    localparam int unsigned LINE_W = 512;
    localparam int unsigned HALF_W = 256;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        DONE,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             words_q, words_d;
    logic [31:0]             lines_q, lines_d;
    logic [31:0]             line_q, line_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    hi_rd_q, hi_rd_d;
    logic [15:0]             epoch_q, epoch_d;
    logic                    x_rd_en_q, x_rd_en_d;
    logic [X_ADDR_WIDTH-1:0] x_rd_addr_q, x_rd_addr_d;
    logic                    mem_wr_valid_q, mem_wr_valid_d;
    logic [63:0]             mem_wr_addr_q, mem_wr_addr_d;
    logic [LINE_W-1:0]       mem_wr_data_q, mem_wr_data_d;
    logic                    done_q, done_d;

    logic [31:0]             line_nx;
    logic                    hi_ok;
    logic                    last_line;
    logic [63:0]             line_addr;

    // Word/line counts, rounded up, in 32-bit arithmetic.
    always_comb begin
        words_d = (dimension + 32'd7) >> 3;
        lines_d = (words_d + 32'd1) >> 1;
    end

    // Per-line helpers: high-half presence, last line, host line address.
    always_comb begin
        line_nx   = line_q + 32'd1;
        hi_ok     = {line_q, 1'b1} < {1'b0, words_q};
        last_line = (line_q == (lines_q - 32'd1));
        line_addr = x_host_base_addr
                  + ((64'(epoch_q) * 64'(lines_q) + 64'(line_q)) << 6);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        line_d         = line_q;
        cnt_d          = cnt_q;
        hi_rd_d        = hi_rd_q;
        epoch_d        = epoch_q;
        x_rd_en_d      = 1'b0;
        x_rd_addr_d    = x_rd_addr_q;
        mem_wr_valid_d = mem_wr_valid_q;
        mem_wr_addr_d  = mem_wr_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (writing_x_to_host_memory_en) begin
                    line_d = 32'd0;
                    if (lines_q == 32'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        epoch_d = epoch_q + 16'd1;
                    end else begin
                        state_d     = READ;
                        x_rd_en_d   = 1'b1;
                        x_rd_addr_d = '0;
                        cnt_d       = '0;
                    end
                end
            end
            READ: begin
                // Low word is on the BRAM port this cycle; issue the high one.
                hi_rd_d     = hi_ok;
                x_rd_en_d   = hi_ok;
                x_rd_addr_d = X_ADDR_WIDTH'({line_q, 1'b1});
                cnt_d       = CNT_W'(1);
                state_d     = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RD_LATENCY)) begin
                    mem_wr_data_d[HALF_W-1:0] = HALF_W'(x_rd_data);
                end
                if (cnt_q == CNT_W'(RD_LATENCY + 1)) begin
                    mem_wr_data_d[LINE_W-1:HALF_W] =
                        hi_rd_q ? HALF_W'(x_rd_data) : '0;
                    mem_wr_valid_d = 1'b1;
                    mem_wr_addr_d  = line_addr;
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (mem_wr_valid_q && mem_wr_ready) begin
                    mem_wr_valid_d = 1'b0;
                    if (last_line) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        epoch_d = epoch_q + 16'd1;
                    end else begin
                        line_d      = line_nx;
                        x_rd_en_d   = 1'b1;
                        x_rd_addr_d = X_ADDR_WIDTH'({line_nx, 1'b0});
                        cnt_d       = '0;
                        state_d     = READ;
                    end
                end
            end
            DONE: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                // Wait for the request to drop so one request yields one pass.
                if (!writing_x_to_host_memory_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!started) begin
            epoch_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            words_q        <= '0;
            lines_q        <= '0;
            line_q         <= '0;
            cnt_q          <= '0;
            hi_rd_q        <= 1'b0;
            epoch_q        <= '0;
            x_rd_en_q      <= 1'b0;
            x_rd_addr_q    <= '0;
            mem_wr_valid_q <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            words_q        <= words_d;
            lines_q        <= lines_d;
            line_q         <= line_d;
            cnt_q          <= cnt_d;
            hi_rd_q        <= hi_rd_d;
            epoch_q        <= epoch_d;
            x_rd_en_q      <= x_rd_en_d;
            x_rd_addr_q    <= x_rd_addr_d;
            mem_wr_valid_q <= mem_wr_valid_d;
            mem_wr_addr_q  <= mem_wr_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            done_q         <= done_d;
        end
    end

    assign writing_x_to_host_memory_done = done_q;
    assign x_rd_en                       = x_rd_en_q;
    assign x_rd_addr                     = x_rd_addr_q;
    assign mem_wr_valid                  = mem_wr_valid_q;
    assign mem_wr_addr                   = mem_wr_addr_q;
    assign mem_wr_data                   = mem_wr_data_q;
    assign x_wb_epoch_count              = epoch_q;

endmodule

// File: tb/tb_sgd_x_host_wr.sv
// Directed bench for sgd_x_host_wr with a fixed-latency BRAM model and a
// negedge monitor logging reads, accepted lines and done pulses.
module tb_sgd_x_host_wr;

    localparam int unsigned XDW = 256;
    localparam int unsigned XAW = 12;
    localparam int unsigned RDL = 2;

    logic            clk;
    logic            rst_n;
    logic            started;
    logic [31:0]     dimension;
    logic [63:0]     x_host_base_addr;
    logic            en;
    logic            done;
    logic            x_rd_en;
    logic [XAW-1:0]  x_rd_addr;
    logic [XDW-1:0]  x_rd_data;
    logic            mem_wr_valid;
    logic            mem_wr_ready;
    logic [63:0]     mem_wr_addr;
    logic [511:0]    mem_wr_data;
    logic [15:0]     epoch;

    int checks   = 0;
    int failures = 0;

    sgd_x_host_wr #(
        .X_DATA_WIDTH(XDW),
        .X_ADDR_WIDTH(XAW),
        .RD_LATENCY  (RDL)
    ) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .started                      (started),
        .dimension                    (dimension),
        .x_host_base_addr             (x_host_base_addr),
        .writing_x_to_host_memory_en  (en),
        .writing_x_to_host_memory_done(done),
        .x_rd_en                      (x_rd_en),
        .x_rd_addr                    (x_rd_addr),
        .x_rd_data                    (x_rd_data),
        .mem_wr_valid                 (mem_wr_valid),
        .mem_wr_ready                 (mem_wr_ready),
        .mem_wr_addr                  (mem_wr_addr),
        .mem_wr_data                  (mem_wr_data),
        .x_wb_epoch_count             (epoch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] word_of(input int a);
        return {8{32'hC0DE_0000 + 32'(a)}};
    endfunction

    function automatic logic [511:0] line_of(input int l, input int words);
        logic [255:0] hi;
        hi = (2 * l + 1 < words) ? word_of(2 * l + 1) : 256'd0;
        return {hi, word_of(2 * l)};
    endfunction

    // BRAM model; returns garbage on cycles with no read.
    logic [255:0] pipe [RDL];
    always @(posedge clk) begin
        pipe[0] <= x_rd_en ? word_of(int'(x_rd_addr)) : {8{32'hDEAD_BEEF}};
        for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
    end
    assign x_rd_data = pipe[RDL-1];

    // Monitor.
    int           rd_q[$];
    logic [63:0]  wa_q[$];
    logic [511:0] wd_q[$];
    int           done_cnt   = 0;
    int           done_long  = 0;
    int           unstable   = 0;
    int           dropped    = 0;
    int           rd_in_send = 0;
    int           valid_cyc  = 0;
    logic         prev_stall = 1'b0;
    logic         prev_done  = 1'b0;
    logic [63:0]  prev_addr;
    logic [511:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (x_rd_en) rd_q.push_back(int'(x_rd_addr));
            if (mem_wr_valid) valid_cyc++;
            if (mem_wr_valid && x_rd_en) rd_in_send++;
            if (prev_stall && !mem_wr_valid) dropped++;
            if (prev_stall && mem_wr_valid &&
                (mem_wr_addr !== prev_addr || mem_wr_data !== prev_data)) unstable++;
            prev_stall = mem_wr_valid && !mem_wr_ready;
            prev_addr  = mem_wr_addr;
            prev_data  = mem_wr_data;
            if (mem_wr_valid && mem_wr_ready) begin
                wa_q.push_back(mem_wr_addr);
                wd_q.push_back(mem_wr_data);
            end
            if (done) begin
                done_cnt++;
                if (prev_done) done_long++;
            end
            prev_done = done;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        done_cnt   = 0;
        done_long  = 0;
        unstable   = 0;
        dropped    = 0;
        rd_in_send = 0;
        valid_cyc  = 0;
    endtask

    // Raise enable, wait for done (bounded), hold, then drop enable.
    task automatic run_wb(input int hold, output int cyc, output bit timeout);
        int start;
        @(posedge clk); #1;
        en    = 1'b1;
        start = done_cnt;
        cyc   = 0;
        while (done_cnt == start && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        timeout = (done_cnt == start);
        repeat (hold) begin @(posedge clk); #1; end
        en = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; started = 1'b1; dimension = 32'd32;
        x_host_base_addr = 64'h1000; en = 1'b0; mem_wr_ready = 1'b1;
        tick(3);
        checks++;
        if (x_rd_en !== 1'b0 || x_rd_addr !== '0 || mem_wr_valid !== 1'b0 ||
            mem_wr_addr !== 64'd0 || mem_wr_data !== 512'd0 || done !== 1'b0 ||
            epoch !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs rd_en=%b rd_addr=%0h valid=%b addr=%0h done=%b epoch=%0d exp all zero",
                     x_rd_en, x_rd_addr, mem_wr_valid, mem_wr_addr, done, epoch);
        end
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_basic();
        int cyc; bit to;
        logic [63:0] ea [2];
        ea[0] = 64'h1000; ea[1] = 64'h1040;
        clear_logs();
        run_wb(0, cyc, to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=done"); end
        checks++;
        if (rd_q.size() != 4) begin failures++; $display("FAIL basic_rd_count got=%0d exp=4", rd_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_q[i] != i) begin failures++; $display("FAIL basic_rd_addr[%0d] got=%0d exp=%0d", i, rd_q[i], i); end
        end
        checks++;
        if (wa_q.size() != 2) begin failures++; $display("FAIL basic_line_count got=%0d exp=2", wa_q.size()); end
        else for (int l = 0; l < 2; l++) begin
            checks++;
            if (wa_q[l] !== ea[l]) begin failures++; $display("FAIL basic_addr[%0d] got=%0h exp=%0h", l, wa_q[l], ea[l]); end
            checks++;
            if (wd_q[l] !== line_of(l, 4)) begin failures++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", l, wd_q[l], line_of(l, 4)); end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
        checks++; if (epoch !== 16'd1) begin failures++; $display("FAIL basic_epoch got=%0d exp=1", epoch); end
    endtask

    task automatic test_stall();
        int n;
        logic [63:0] ea [2];
        ea[0] = 64'h1080; ea[1] = 64'h10C0;
        clear_logs();
        mem_wr_ready = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        n = 0;
        while (mem_wr_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (mem_wr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_rise got=%b exp=1", mem_wr_valid); end
        tick(5);
        checks++; if (mem_wr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_held got=%b exp=1", mem_wr_valid); end
        mem_wr_ready = 1'b1;
        n = 0;
        while (done_cnt == 0 && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL stall_done got=%0d exp=1", done_cnt); end
        en = 1'b0;
        tick(4);
        checks++; if (unstable != 0) begin failures++; $display("FAIL stall_stable got=%0d changes exp=0", unstable); end
        checks++; if (dropped != 0) begin failures++; $display("FAIL stall_dropped got=%0d exp=0", dropped); end
        checks++; if (rd_in_send != 0) begin failures++; $display("FAIL stall_rd_in_send got=%0d exp=0", rd_in_send); end
        checks++;
        if (wa_q.size() != 2) begin failures++; $display("FAIL stall_line_count got=%0d exp=2", wa_q.size()); end
        else for (int l = 0; l < 2; l++) begin
            checks++;
            if (wa_q[l] !== ea[l]) begin failures++; $display("FAIL stall_addr[%0d] got=%0h exp=%0h", l, wa_q[l], ea[l]); end
            checks++;
            if (wd_q[l] !== line_of(l, 4)) begin failures++; $display("FAIL stall_data[%0d] got=%0h exp=%0h", l, wd_q[l], line_of(l, 4)); end
        end
        checks++; if (epoch !== 16'd2) begin failures++; $display("FAIL stall_epoch got=%0d exp=2", epoch); end
    endtask

    task automatic test_partial();
        int cyc; bit to;
        logic [63:0] ea [2];
        ea[0] = 64'h1100; ea[1] = 64'h1140;
        dimension = 32'd24;
        tick(2);
        clear_logs();
        run_wb(0, cyc, to);
        checks++; if (to) begin failures++; $display("FAIL partial_timeout got=timeout exp=done"); end
        checks++;
        if (rd_q.size() != 3) begin failures++; $display("FAIL partial_rd_count got=%0d exp=3", rd_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_q[i] != i) begin failures++; $display("FAIL partial_rd_addr[%0d] got=%0d exp=%0d", i, rd_q[i], i); end
        end
        checks++;
        if (wa_q.size() != 2) begin failures++; $display("FAIL partial_line_count got=%0d exp=2", wa_q.size()); end
        else begin
            for (int l = 0; l < 2; l++) begin
                checks++;
                if (wa_q[l] !== ea[l]) begin failures++; $display("FAIL partial_addr[%0d] got=%0h exp=%0h", l, wa_q[l], ea[l]); end
                checks++;
                if (wd_q[l] !== line_of(l, 3)) begin failures++; $display("FAIL partial_data[%0d] got=%0h exp=%0h", l, wd_q[l], line_of(l, 3)); end
            end
            checks++;
            if (wd_q[1][511:256] !== 256'd0) begin failures++; $display("FAIL partial_hi_zero got=%0h exp=0", wd_q[1][511:256]); end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL partial_done_count got=%0d exp=1", done_cnt); end
        checks++; if (epoch !== 16'd3) begin failures++; $display("FAIL partial_epoch got=%0d exp=3", epoch); end
    endtask

    task automatic test_hold_enable();
        int cyc; bit to;
        dimension = 32'd8;
        tick(2);
        clear_logs();
        run_wb(3, cyc, to);
        tick(4);
        checks++; if (to) begin failures++; $display("FAIL hold_timeout got=timeout exp=done"); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL hold_done_count got=%0d exp=1", done_cnt); end
        checks++; if (done_long != 0) begin failures++; $display("FAIL hold_done_width got=%0d extra cycles exp=0", done_long); end
        checks++;
        if (rd_q.size() != 1) begin failures++; $display("FAIL hold_rd_count got=%0d exp=1", rd_q.size()); end
        checks++;
        if (wa_q.size() != 1) begin failures++; $display("FAIL hold_line_count got=%0d exp=1", wa_q.size()); end
        else begin
            checks++;
            if (wa_q[0] !== 64'h10C0) begin failures++; $display("FAIL hold_addr got=%0h exp=10c0", wa_q[0]); end
            checks++;
            if (wd_q[0] !== line_of(0, 1)) begin failures++; $display("FAIL hold_data got=%0h exp=%0h", wd_q[0], line_of(0, 1)); end
        end
        checks++; if (epoch !== 16'd4) begin failures++; $display("FAIL hold_epoch got=%0d exp=4", epoch); end
    endtask

    task automatic test_zero_dim();
        int cyc; bit to;
        dimension = 32'd0;
        tick(2);
        clear_logs();
        run_wb(0, cyc, to);
        checks++; if (to || cyc > 2) begin failures++; $display("FAIL zero_done_latency got=%0d cycles exp<=2", cyc); end
        checks++; if (rd_q.size() != 0) begin failures++; $display("FAIL zero_rd_count got=%0d exp=0", rd_q.size()); end
        checks++; if (valid_cyc != 0) begin failures++; $display("FAIL zero_valid got=%0d cycles exp=0", valid_cyc); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
        checks++; if (epoch !== 16'd5) begin failures++; $display("FAIL zero_epoch got=%0d exp=5", epoch); end
    endtask

    task automatic test_reset_mid_send();
        int n;
        dimension = 32'd32;
        tick(2);
        mem_wr_ready = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        n = 0;
        while (mem_wr_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (mem_wr_valid !== 1'b1) begin failures++; $display("FAIL rstmid_valid got=%b exp=1", mem_wr_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (x_rd_en !== 1'b0 || x_rd_addr !== '0 || mem_wr_valid !== 1'b0 ||
            mem_wr_addr !== 64'd0 || mem_wr_data !== 512'd0 || done !== 1'b0 ||
            epoch !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_outputs rd_en=%b valid=%b addr=%0h done=%b epoch=%0d exp all zero",
                     x_rd_en, mem_wr_valid, mem_wr_addr, done, epoch);
        end
        en = 1'b0;
        mem_wr_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        clear_logs();
        tick(8);
        checks++;
        if (rd_q.size() != 0 || valid_cyc != 0 || done_cnt != 0) begin
            failures++;
            $display("FAIL rstmid_quiet reads=%0d valid=%0d done=%0d exp all 0", rd_q.size(), valid_cyc, done_cnt);
        end
    endtask

    task automatic test_started_clear();
        int cyc; bit to;
        clear_logs();
        run_wb(0, cyc, to);
        checks++; if (epoch !== 16'd1) begin failures++; $display("FAIL started_epoch_pre got=%0d exp=1", epoch); end
        started = 1'b0;
        tick(1);
        checks++; if (epoch !== 16'd0) begin failures++; $display("FAIL started_epoch_clear got=%0d exp=0", epoch); end
        started = 1'b1;
        tick(1);
        clear_logs();
        run_wb(0, cyc, to);
        checks++; if (to) begin failures++; $display("FAIL started_timeout got=timeout exp=done"); end
        checks++;
        if (wa_q.size() != 2) begin failures++; $display("FAIL started_line_count got=%0d exp=2", wa_q.size()); end
        else begin
            checks++;
            if (wa_q[0] !== 64'h1000 || wa_q[1] !== 64'h1040) begin
                failures++;
                $display("FAIL started_addr got=%0h,%0h exp=1000,1040", wa_q[0], wa_q[1]);
            end
        end
        checks++; if (epoch !== 16'd1) begin failures++; $display("FAIL started_epoch_post got=%0d exp=1", epoch); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_partial();
        test_hold_enable();
        test_zero_dim();
        test_reset_mid_send();
        test_started_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
